// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and default framing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_state_t;

   localparam int OS_DEFAULT        = 8;
   localparam int DATA_BITS_DEFAULT = 8;

endpackage

// File: rtl/uartrx_sync2.sv
// Generic 2-FF synchronizer for asynchronous single-bit inputs; INIT is the reset value.
// Latency: 2 clk from d to q.
// Backpressure: none.
module sync2 #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= INIT;
         q    <= INIT;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uartrx.sv
// 8N1 LSB-first UART receiver with one-entry valid/ready holding register, framing-error pulse and sticky overrun.
// Latency: valid rises 1 clk after the clken cycle that samples the stop bit (+2 clk rx synchronizer).
// Backpressure: holding register full and ready low at commit drops the new byte and sets overrun.
module uartrx
   import uart_pkg::*;
#(
   parameter int OS        = OS_DEFAULT,
   parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clken,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 clr_err
);

   localparam int CNT_W = (OS > 2) ? $clog2(OS) : 1;
   localparam int BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
   localparam int MID   = OS / 2 - 1;

   uart_state_t          state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIT_W-1:0]     bitn, bitn_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 rx_s;
   logic                 commit;
   logic                 ferr_n;

   sync2 #(.INIT(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bitn_n  = bitn;
      shreg_n = shreg;
      commit  = 1'b0;
      ferr_n  = 1'b0;
      if (clken) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_n = START;
                  cnt_n   = '0;
               end
            end
            START: begin
               // Re-check the line half a bit in; a high here was a glitch.
               if (cnt == CNT_W'(MID)) begin
                  if (rx_s) begin
                     state_n = IDLE;
                  end else begin
                     state_n = DATA;
                     cnt_n   = '0;
                     bitn_n  = '0;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_W'(OS - 1)) begin
                  shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                  cnt_n   = '0;
                  if (bitn == BIT_W'(DATA_BITS - 1)) begin
                     state_n = STOP;
                  end else begin
                     bitn_n = bitn + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_W'(OS - 1)) begin
                  cnt_n = '0;
                  if (rx_s) begin
                     commit  = 1'b1;
                     state_n = IDLE;
                  end else begin
                     ferr_n  = 1'b1;
                     state_n = BREAK;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            BREAK: begin
               // A held-low line must return high before the next start bit counts.
               if (rx_s) begin
                  state_n = IDLE;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bitn      <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bitn      <= bitn_n;
         shreg     <= shreg_n;
         frame_err <= ferr_n;
         if (commit) begin
            if (!valid || ready) begin
               data  <= shreg;
               valid <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         // A fresh overrun beats a simultaneous clear.
         if (commit && valid && !ready) begin
            overrun <= 1'b1;
         end else if (clr_err) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uartrx.sv
// Directed bench for uartrx: bit-accurate 8N1 frames aligned to a bench-generated clken.
`timescale 1ns/1ps
module tb_uartrx;
   import uart_pkg::*;

   localparam int OS  = 8;
   localparam int DIV = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clken = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;

   logic run = 1'b1;
   int   div = 0;
   int   total = 0;
   int   passed = 0;
   int   ferr_cnt = 0;
   int   vrise = 0;
   int   vfall = 0;
   logic vprev = 1'b0;
   int   f0, r0, d0;

   uartrx #(.OS(OS), .DATA_BITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .clken     (clken),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .clr_err   (clr_err)
   );

   always #16.667 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         if (run) begin
            clken = (div == DIV - 1);
            div   = (div == DIV - 1) ? 0 : div + 1;
         end else begin
            clken = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (frame_err === 1'b1) ferr_cnt++;
      if (valid === 1'b1 && vprev === 1'b0) vrise++;
      if (valid === 1'b0 && vprev === 1'b1) vfall++;
      vprev = valid;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not complete, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      while (clken !== 1'b1) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      rx = b;
      repeat (OS) tick();
   endtask

   // Stop bit is sampled on its (OS/2+1)-th tick; acc raises ready on exactly that clk.
   task automatic send_frame(input logic [7:0] d, input logic stop, input bit acc);
      tick();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      @(negedge clk);
      rx = stop;
      repeat (OS / 2) tick();
      if (acc) begin
         repeat (DIV) @(negedge clk);
         ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         ready = 1'b0;
         repeat (OS / 2 - 1) tick();
      end else begin
         repeat (OS / 2) tick();
      end
      @(negedge clk);
   endtask

   task automatic drain();
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      send_bit(1'b1);

      // 1: basic receive and handshake
      send_frame(8'h41, 1'b1, 1'b0);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_data", 32'(data), 32'h41);
      chk("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
      @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("t1_valid_drop", 32'(valid), 32'd0);
      chk("t1_data_hold", 32'(data), 32'h41);

      // 2: overrun and clear
      send_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'hA3, 1'b1, 1'b0);
      chk("t2_data", 32'(data), 32'h55);
      chk("t2_valid", 32'(valid), 32'd1);
      chk("t2_ovr", 32'(overrun), 32'd1);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("t2_ovr_clr", 32'(overrun), 32'd0);
      drain();
      chk("t2_drained", 32'(valid), 32'd0);

      // 3: framing error, break, recovery
      f0 = ferr_cnt;
      r0 = vrise;
      send_frame(8'h00, 1'b0, 1'b0);
      chk("t3_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
      chk("t3_ferr_now", 32'(frame_err), 32'd0);
      chk("t3_valid", 32'(valid), 32'd0);
      repeat (3) send_bit(1'b0);
      send_bit(1'b1);
      chk("t3_break_nobyte", 32'(vrise - r0), 32'd0);
      send_frame(8'h7E, 1'b1, 1'b0);
      chk("t3_data", 32'(data), 32'h7E);
      chk("t3_one_byte", 32'(vrise - r0), 32'd1);
      chk("t3_ferr_total", 32'(ferr_cnt - f0), 32'd1);
      drain();

      // 4: start-bit glitch
      f0 = ferr_cnt;
      r0 = vrise;
      send_bit(1'b1);
      @(negedge clk);
      rx = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rx = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);
      chk("t4_state", 32'(dut.state), 32'(IDLE));
      chk("t4_valid", 32'(valid), 32'd0);
      chk("t4_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h31, 1'b1, 1'b0);
      chk("t4_data", 32'(data), 32'h31);
      chk("t4_one_byte", 32'(vrise - r0), 32'd1);
      drain();

      // 5: accept on the exact commit cycle
      send_frame(8'h12, 1'b1, 1'b0);
      chk("t5_first", 32'(data), 32'h12);
      d0 = vfall;
      send_frame(8'h34, 1'b1, 1'b1);
      chk("t5_data", 32'(data), 32'h34);
      chk("t5_valid", 32'(valid), 32'd1);
      chk("t5_ovr", 32'(overrun), 32'd0);
      chk("t5_no_gap", 32'(vfall - d0), 32'd0);

      // 6: reset at data bit 4 of 0xFF
      tick();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      @(negedge clk);
      rx = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_data", 32'(data), 32'd0);
      chk("t6_rst_valid", 32'(valid), 32'd0);
      chk("t6_rst_ferr", 32'(frame_err), 32'd0);
      chk("t6_rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      f0 = ferr_cnt;
      repeat (6) tick();
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("t6_no_byte", 32'(valid), 32'd0);
      chk("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h0D, 1'b1, 1'b0);
      chk("t6_data", 32'(data), 32'h0D);
      chk("t6_valid", 32'(valid), 32'd1);
      drain();

      // clken frozen mid-frame: 0x5A, paused during data bit 2
      tick();
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (3) tick();
      run = 1'b0;
      repeat (400) @(negedge clk);
      chk("frz_state", 32'(dut.state), 32'(DATA));
      chk("frz_bitn", 32'(dut.bitn), 32'd2);
      chk("frz_valid", 32'(valid), 32'd0);
      @(posedge clk);
      run = 1'b1;
      repeat (5) tick();
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk);
      chk("frz_data", 32'(data), 32'h5A);
      chk("frz_valid_end", 32'(valid), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
